// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential signed ALU.
package alu_pkg;

    localparam int W_DEFAULT = 8;

    // Codes 5..7 all decode as PASS; only 5 carries a name.
    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_DIV  = 3'd3,
        OP_MOD  = 3'd4,
        OP_PASS = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_e;

endpackage

// File: rtl/alu_div_seq.sv
// Unsigned restoring divider: one quotient bit per cycle, W cycles per division.
// done_o and quot_o/rem_o describe the final iteration while it is being computed.
module alu_div_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         done_o,
    output logic [W-1:0] quot_o,
    output logic [W-1:0] rem_o
);

    localparam int CW = $clog2(W);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [W-1:0]  quot_q, quot_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [W:0]    shifted;
    logic [W:0]    trial;
    logic          ge;

    // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;

        shifted = {rem_q, quot_q[W-1]};
        ge      = shifted >= {1'b0, dvs_q};
        trial   = shifted - {1'b0, dvs_q};
        quot_o  = {quot_q[W-2:0], ge};
        rem_o   = ge ? trial[W-1:0] : shifted[W-1:0];
        done_o  = busy_q && (cnt_q == CW'(W - 1));

        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            quot_d = dividend_i;
            rem_d  = '0;
            dvs_d  = divisor_i;
        end else if (busy_q) begin
            quot_d = quot_o;
            rem_d  = rem_o;
            cnt_d  = cnt_q + 1'b1;
            if (done_o) begin
                busy_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
        end
    end

endmodule

// File: rtl/alu_seq_p.sv
// Sequential signed ALU with valid/ready handshake; single-cycle ADD/SUB/MUL/PASS,
// W-cycle DIV/MOD via alu_div_seq with sign fix-up and special cases handled here.
module alu_seq_p
    import alu_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  op_e          op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] c,
    output logic         z,
    output logic         n,
    output logic         v,
    output logic         dz
);

    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONES    = '1;

    state_e         state_q, state_d;
    op_e            op_q, op_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [W-1:0]   c_q, c_d;
    logic           z_q, z_d, n_q, n_d, v_q, v_d, dz_q, dz_d;

    logic [W-1:0]   sum, dif;
    logic [2*W-1:0] a_ext, b_ext, prod;
    logic           add_ovf, sub_ovf, mul_ovf;
    logic [W-1:0]   a_mag, b_mag;
    logic           div_start, div_done;
    logic [W-1:0]   quot, rem, q_fix, r_fix;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign c  = c_q;
    assign z  = z_q;
    assign n  = n_q;
    assign v  = v_q;
    assign dz = dz_q;

    always_comb begin
        sum     = a + b;
        dif     = a - b;
        a_ext   = {{W{a[W-1]}}, a};
        b_ext   = {{W{b[W-1]}}, b};
        prod    = a_ext * b_ext;
        add_ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
        sub_ovf = (a[W-1] != b[W-1]) && (dif[W-1] != a[W-1]);
        // The product fits when its top W+1 bits are a pure sign extension.
        mul_ovf = !((&prod[2*W-1:W-1]) || !(|prod[2*W-1:W-1]));
        a_mag   = a[W-1] ? (~a + 1'b1) : a;
        b_mag   = b[W-1] ? (~b + 1'b1) : b;
    end

    assign div_start = in_ready && in_valid && ((op == OP_DIV) || (op == OP_MOD));

    alu_div_seq #(.W(W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .done_o     (div_done),
        .quot_o     (quot),
        .rem_o      (rem)
    );

    // Quotient is negative when operand signs differ; remainder follows the dividend.
    assign q_fix = (a_q[W-1] ^ b_q[W-1]) ? (~quot + 1'b1) : quot;
    assign r_fix = a_q[W-1] ? (~rem + 1'b1) : rem;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        v_d     = v_q;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    v_d     = 1'b0;
                    dz_d    = 1'b0;
                    state_d = S_DONE;
                    case (op)
                        OP_ADD: begin
                            c_d = sum;
                            v_d = add_ovf;
                        end
                        OP_SUB: begin
                            c_d = dif;
                            v_d = sub_ovf;
                        end
                        OP_MUL: begin
                            c_d = prod[W-1:0];
                            v_d = mul_ovf;
                        end
                        OP_DIV, OP_MOD: begin
                            c_d     = c_q;
                            state_d = S_DIV;
                        end
                        default: c_d = a;
                    endcase
                end
            end
            S_DIV: begin
                if (div_done) begin
                    state_d = S_DONE;
                    v_d     = 1'b0;
                    dz_d    = 1'b0;
                    if (b_q == '0) begin
                        dz_d = 1'b1;
                        c_d  = (op_q == OP_DIV) ? ONES : a_q;
                    end else if (op_q == OP_DIV) begin
                        c_d = q_fix;
                        v_d = (a_q == MIN_VAL) && (b_q == ONES);
                    end else begin
                        c_d = r_fix;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        z_d = (c_d == '0);
        n_d = c_d[W-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            z_q     <= 1'b1;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            z_q     <= z_d;
            n_q     <= n_d;
            v_q     <= v_d;
            dz_q    <= dz_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_p.sv
// Directed bench for alu_seq_p: one W=8 and one W=16 instance, exercised in turn.
module tb_alu_seq_p;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready;
    op_e         op;
    logic [31:0] a_drv, b_drv;
    logic        cur;

    logic        rdy8, rdy16, ov8, ov16;
    logic [7:0]  c8;
    logic [15:0] c16;
    logic        z8, z16, n8, n16, v8, v16, dz8, dz16;

    logic        in_ready_m, out_valid_m, z_m, n_m, v_m, dz_m;
    logic [31:0] c_m;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_seq_p #(.W(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & ~cur),
        .in_ready  (rdy8),
        .op        (op),
        .a         (a_drv[7:0]),
        .b         (b_drv[7:0]),
        .out_valid (ov8),
        .out_ready (out_ready & ~cur),
        .c         (c8),
        .z         (z8),
        .n         (n8),
        .v         (v8),
        .dz        (dz8)
    );

    alu_seq_p #(.W(16)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & cur),
        .in_ready  (rdy16),
        .op        (op),
        .a         (a_drv[15:0]),
        .b         (b_drv[15:0]),
        .out_valid (ov16),
        .out_ready (out_ready & cur),
        .c         (c16),
        .z         (z16),
        .n         (n16),
        .v         (v16),
        .dz        (dz16)
    );

    assign in_ready_m  = cur ? rdy16 : rdy8;
    assign out_valid_m = cur ? ov16  : ov8;
    assign c_m         = cur ? {{16{c16[15]}}, c16} : {{24{c8[7]}}, c8};
    assign z_m         = cur ? z16  : z8;
    assign n_m         = cur ? n16  : n8;
    assign v_m         = cur ? v16  : v8;
    assign dz_m        = cur ? dz16 : dz8;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Issue one request, wait for the result, check it, optionally stall, then retire it.
    task automatic run_op(input string tag, input op_e o, input int av, input int bv,
                          input int exp_c, input bit exp_v, input bit exp_dz,
                          input int hold, input bit noise);
        int w;
        int lat;
        int exp_lat;
        w       = cur ? 16 : 8;
        exp_lat = ((o == OP_DIV) || (o == OP_MOD)) ? w + 1 : 1;

        check({tag, ":in_ready"}, 32'(in_ready_m), 32'(1));
        op       = o;
        a_drv    = av;
        b_drv    = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = noise;
        op       = OP_ADD;
        a_drv    = $urandom;
        b_drv    = $urandom;

        lat = 1;
        while (!out_valid_m && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (noise) begin
                op    = op_e'(3'($urandom_range(0, 7)));
                a_drv = $urandom;
                b_drv = $urandom;
            end
        end
        check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ":c"},  c_m,          32'(exp_c));
        check({tag, ":v"},  32'(v_m),     32'(exp_v));
        check({tag, ":dz"}, 32'(dz_m),    32'(exp_dz));
        check({tag, ":z"},  32'(z_m),     32'(exp_c == 0));
        check({tag, ":n"},  32'(n_m),     32'(exp_c < 0));

        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ":hold_c"},        c_m,                32'(exp_c));
            check({tag, ":hold_flags"},    {28'd0, z_m, n_m, v_m, dz_m},
                  {28'd0, exp_c == 0, exp_c < 0, exp_v, exp_dz});
            check({tag, ":hold_in_ready"}, 32'(in_ready_m),    32'(0));
            check({tag, ":hold_valid"},    32'(out_valid_m),   32'(1));
        end

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, ":ret_in_ready"}, 32'(in_ready_m),  32'(1));
        check({tag, ":ret_valid"},    32'(out_valid_m), 32'(0));
    endtask

    task automatic reset_mid_div(input string tag);
        check({tag, ":pre_c_nonzero"}, 32'(c_m != 0), 32'(1));
        op       = OP_DIV;
        a_drv    = 50;
        b_drv    = 3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check({tag, ":in_div"}, 32'(in_ready_m), 32'(0));
        rst = 1'b1;
        #1;
        check({tag, ":rst_valid"}, 32'(out_valid_m), 32'(0));
        check({tag, ":rst_c"},     c_m,              32'(0));
        check({tag, ":rst_z"},     32'(z_m),         32'(1));
        check({tag, ":rst_nvdz"},  {29'd0, n_m, v_m, dz_m}, 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        check({tag, ":post_rst_ready"}, 32'(in_ready_m), 32'(1));
        run_op({tag, ":div_after"}, OP_DIV, 50, 3, 16, 1'b0, 1'b0, 0, 1'b0);
        run_op({tag, ":mod_after"}, OP_MOD, 50, 3, 2,  1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic run_suite();
        int w;
        int mn;
        int mx;
        w  = cur ? 16 : 8;
        mn = -(1 <<< (w - 1));
        mx = (1 <<< (w - 1)) - 1;

        run_op("add_ovf",   OP_ADD, 100, 50, (w == 8) ? -106 : 150, w == 8, 1'b0, 0, 1'b0);
        run_op("add_zero",  OP_ADD, 5, -5, 0, 1'b0, 1'b0, 0, 1'b0);
        run_op("sub_min",   OP_SUB, mn, 1, mx, 1'b1, 1'b0, 0, 1'b0);
        run_op("sub_neg",   OP_SUB, 5, 9, -4, 1'b0, 1'b0, 0, 1'b0);
        run_op("mul_neg",   OP_MUL, -3, 7, -21, 1'b0, 1'b0, 0, 1'b0);
        run_op("mul_16",    OP_MUL, 16, 16, (w == 8) ? 0 : 256, w == 8, 1'b0, 0, 1'b0);
        run_op("div_m7_2",  OP_DIV, -7, 2, -3, 1'b0, 1'b0, 5, 1'b0);
        run_op("mod_m7_2",  OP_MOD, -7, 2, -1, 1'b0, 1'b0, 0, 1'b1);
        run_op("div_7_m2",  OP_DIV, 7, -2, -3, 1'b0, 1'b0, 0, 1'b0);
        run_op("mod_7_m2",  OP_MOD, 7, -2, 1, 1'b0, 1'b0, 0, 1'b0);
        run_op("div_m7_m2", OP_DIV, -7, -2, 3, 1'b0, 1'b0, 0, 1'b0);
        run_op("mod_m7_m2", OP_MOD, -7, -2, -1, 1'b0, 1'b0, 0, 1'b0);
        run_op("div_by0",   OP_DIV, 5, 0, -1, 1'b0, 1'b1, 0, 1'b0);
        run_op("mod_by0",   OP_MOD, -6, 0, -6, 1'b0, 1'b1, 0, 1'b0);
        run_op("div_min_m1", OP_DIV, mn, -1, mn, 1'b1, 1'b0, 0, 1'b0);
        run_op("mod_min_m1", OP_MOD, mn, -1, 0, 1'b0, 1'b0, 0, 1'b0);
        run_op("div_100_7", OP_DIV, 100, 7, 14, 1'b0, 1'b0, 0, 1'b0);
        run_op("mod_100_7", OP_MOD, 100, 7, 2, 1'b0, 1'b0, 0, 1'b0);
        run_op("pass_5",    OP_PASS, 42, 3, 42, 1'b0, 1'b0, 0, 1'b0);
        run_op("pass_6",    op_e'(3'd6), -9, 1, -9, 1'b0, 1'b0, 0, 1'b0);
        run_op("div_min_3", OP_DIV, mn, 3, (w == 8) ? -42 : -10922, 1'b0, 1'b0, 0, 1'b0);
        run_op("mod_min_3", OP_MOD, mn, 3, -2, 1'b0, 1'b0, 0, 1'b0);
        reset_mid_div("rst_mid_div");
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = OP_ADD;
        a_drv     = '0;
        b_drv     = '0;
        cur       = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            cur = s[0];
            #1;
            check("reset_valid", 32'(out_valid_m), 32'(0));
            check("reset_c",     c_m,              32'(0));
            check("reset_z",     32'(z_m),         32'(1));
            check("reset_nvdz",  {29'd0, n_m, v_m, dz_m}, 32'(0));
        end
        cur = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready_m), 32'(1));

        for (int s = 0; s < 2; s++) begin
            cur = s[0];
            #1;
            run_suite();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
